key_debouncer: RTL
==================

# key_debouncer

Cleans a mechanical push-button input and produces the single-bit `in` stimulus for the Lab 7 sequence FSM. It sits directly upstream of that FSM. The block synchronises the raw key into the clock domain and filters bounce with a four-state debounce machine. It outputs a stable level, one-cycle press/release pulses, and its current state so the board LEDs can show it the same way the FSM shows `out_state`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronised samples required to accept a level change (10 ms at 50 MHz); legal range ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means the raw key reads 0 when pressed; 0 means it reads 1 when pressed.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset asserted).
- `key_raw` in 1: unsynchronised button pin.
- `out` out 1: debounced pressed level (1 = pressed); feeds the FSM `in`.
- `press_pulse` out 1: one-cycle strobe on an accepted press.
- `release_pulse` out 1: one-cycle strobe on an accepted release.
- `out_state` out 2: current debounce state encoding.

## Operation
- **Normalisation:** `key_n = key_raw XOR ACTIVE_LOW`, so 1 means pressed.
- **Synchronisation:** `key_n` passes through two flops to give `key_s`. Both flops reset to 0.
- **Counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, is cleared on every state entry.
- **State `S_IDLE` (2'b00):** released and stable.
  - `key_s=1` → go to `S_PRESS_WAIT` and clear `cnt`.
- **State `S_PRESS_WAIT` (2'b01):** candidate press.
  - `key_s=0` → return to `S_IDLE` (bounce rejected, no pulse).
  - `key_s=1` and `cnt==DEBOUNCE_CYCLES-1` → go to `S_HELD` and assert `press_pulse`.
  - Otherwise, `cnt++`.
- **State `S_HELD` (2'b10):** pressed and stable.
  - `key_s=0` → go to `S_RELEASE_WAIT` and clear `cnt`.
- **State `S_RELEASE_WAIT` (2'b11):** candidate release.
  - `key_s=1` → return to `S_HELD` (no pulse).
  - `key_s=0` and `cnt==DEBOUNCE_CYCLES-1` → go to `S_IDLE` and assert `release_pulse`.
  - Otherwise, `cnt++`.
- **Output decode:**
  - `out = 1` in `S_HELD` and `S_RELEASE_WAIT`; `out = 0` otherwise.
  - `out_state` is the state register.
- **Registering:** all outputs are registered. No output has a combinational path from `key_raw`.
- **Counter bound:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.

## Timing
- **Reset values:** while `rst=0`:
  - state = `S_IDLE`, `cnt=0`, sync flops = 0;
  - `out=0`, `press_pulse=0`, `release_pulse=0`, `out_state=2'b00`.
  - This applies immediately and asynchronously.
- **Reset mid-operation:** reset may assert in any state, including mid-count or mid-pulse. It forces the reset values at once, and no pulse is emitted afterwards. Deassertion is synchronised externally; the first active edge after `rst` rises evaluates normally.
- **Press latency:** let edge 0 be the first edge that samples the pressed level.
  - `key_s=1` after edge 1.
  - `S_PRESS_WAIT` after edge 2.
  - `S_HELD`, `out=1` and `press_pulse=1` after edge `DEBOUNCE_CYCLES+2`.
  - The press must stay stable through edge `DEBOUNCE_CYCLES+1`.
- **Release latency:** symmetric; `out` falls and `release_pulse` fires after edge `DEBOUNCE_CYCLES+2`.
- **Pulse width:** each pulse is high for exactly one cycle, coincident with the first cycle of the new stable state.
- **Pulse exclusivity:** `press_pulse` and `release_pulse` are never high together.
- **Glitch rejection:** any opposite sample during a wait state aborts the wait on that edge and produces no output change. The count restarts from 0 on the next candidate.
- **Held key:** after the press pulse, no repeat pulses occur while `key_s` stays 1.

## Structure
- Package `lab7_pkg` holds:
  - the `debounce_state_t` typedef/localparams `S_IDLE`, `S_PRESS_WAIT`, `S_HELD`, `S_RELEASE_WAIT`, with the encodings above;
  - the counter-width function.
- Sub-module `sync_2ff` is the two-flop synchroniser with async active-low reset to 0. It is reused for other board inputs.
- The top level instantiates `sync_2ff` and holds the FSM, counter and output registers. Its `out` connects directly to the downstream FSM `in`.

## Test plan
Bench conditions: `DEBOUNCE_CYCLES=4`, `ACTIVE_LOW=1`, clock period 10000 ps, `rst` low for the first 10000 ps.

- **Reset:** hold `rst=0` with `key_raw` toggling → `out=0`, both pulses 0, `out_state=00` throughout.
- **Clean press:** drive `key_raw` 1→0 and hold for 10 cycles → `out_state` 01 after edge 2; `out=1`, `out_state=10` and `press_pulse` high for one cycle after edge 6.
- **Bounce:** drive `key_raw` low 2 cycles, high 1, low 2, high 1, then high steady → `out` stays 0, no pulses, `out_state` returns to 00.
- **Clean release from held:** drive `key_raw` 0→1 and hold for 10 cycles → `out_state` 11, then 00 after edge 6; `out` falls; `release_pulse` high for one cycle.
- **Reset mid-count:** assert `rst=0` while `out_state=01` with `cnt=2` → immediate `out_state=00`, `cnt=0`. After release of `rst` with the key still pressed, a full 6-edge press latency applies.
- **Long hold:** hold the key for 50 cycles → exactly one `press_pulse`, and `out` stays 1 continuously.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// lab7_pkg : shared debounce state encoding and counter sizing helper
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lab7_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'b00,
        S_PRESS_WAIT   = 2'b01,
        S_HELD         = 2'b10,
        S_RELEASE_WAIT = 2'b11
    } debounce_state_t;

    // Never narrower than one bit so the smallest legal setting still elaborates.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debouncer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchroniser, asynchronous active-low reset to 0
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer : synchronises and debounces a push-button, emits level/pulses
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debouncer
    import lab7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    output logic       out,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [1:0] out_state
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic key_n;
    logic key_s;

    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign key_n = key_raw ^ ACTIVE_LOW;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_n),
        .q_o (key_s)
    );

    // Counter is cleared on every state change so each wait starts from zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!key_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (key_s) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_d = (state_d == S_HELD) || (state_d == S_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign out           = out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign out_state     = state_q;

endmodule

`default_nettype wire
